aibnd_dcc_cal_ctl: RTL and testbench
====================================

# aibnd_dcc_cal_ctl

Duty-cycle-correction calibration controller. It sits directly upstream of the DCC code flops and computes the next delay-trim code they capture. The code is driven by a filtered duty-cycle phase-detector decision. An FSM settles, filters, steps the code, and declares lock after a set number of direction reversals.

## Interface
Parameters:
- CODE_W, 5: width of the DCC trim code; reset/start value is midscale 2^(CODE_W-1).
- SETTLE_CYC, 8: wait cycles after each code change before sampling; minimum 1.
- FILT_TH, 4: accumulator magnitude that yields a decision; minimum 1.
- LOCK_TOGGLES, 4: reversal/saturation/timeout events required for lock; minimum 1.

Ports:
- clk  in  1  calibration clock; all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- vcc_aibnd  in  1  supply pin; no functional effect in RTL.
- vss_aibnd  in  1  ground pin; no functional effect in RTL.
- cal_en  in  1  level enable; high runs or holds calibration, low aborts to IDLE.
- pd_dn  in  1  phase-detector sample, one per cycle in SAMPLE; 1 = duty too high, decrement code.
- dcc_code  out  CODE_W  registered trim code to DCC flops; reset midscale.
- cal_busy  out  1  high in SETTLE/SAMPLE/ADJUST; reset 0.
- cal_done  out  1  high in LOCKED; reset 0.
- cal_sat  out  1  sticky, set when a step is blocked at 0 or max; cleared by rst or cal_en low; reset 0.

## Operation
- States: IDLE, SETTLE, SAMPLE, ADJUST, LOCKED.
- IDLE: on cal_en=1, go to SETTLE. Clear the settle counter, accumulator, sample counter, event counter and last-direction flag. dcc_code is not reloaded; it starts from its current value.
- SETTLE: count SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE: a signed accumulator adds +1 for pd_dn=1 and -1 for pd_dn=0.
  - Reaching +FILT_TH is a DOWN decision; reaching -FILT_TH is an UP decision. Go to ADJUST.
  - After 4*FILT_TH samples with no decision, a timeout occurs: counts as one event, no code change, go back to SETTLE.
- ADJUST: step dcc_code by ±1.
  - An event is counted if the direction is opposite to the last applied direction.
  - An event is also counted if the step would pass 0 or 2^CODE_W-1. In that case the code holds and cal_sat is set.
  - If the event count reaches LOCK_TOGGLES, go to LOCKED; otherwise go to SETTLE.
- LOCKED: dcc_code is frozen unless the tracking option is compiled in (see Configuration).
- cal_en=0 in any non-IDLE state: IDLE next cycle; cal_busy, cal_done and cal_sat cleared; dcc_code held.
- rst overrides everything, including a simultaneous cal_en rise.
- Widths:
  - Accumulator: signed, clog2(FILT_TH)+2 bits.
  - Sample counter: clog2(4*FILT_TH)+1 bits.
  - Event counter: saturates at LOCK_TOGGLES.
  - Code arithmetic: saturating, never wraps.

## Timing
- Cycle 0 is the cycle in which cal_en is first sampled high in IDLE.
- SETTLE occupies cycles 1..SETTLE_CYC.
- The first SAMPLE cycle is SETTLE_CYC+1.
- A decision after n samples means ADJUST occupies cycle SETTLE_CYC+n+1. The new dcc_code is visible at cycle SETTLE_CYC+n+2.
- Loop period per step is SETTLE_CYC+FILT_TH+1 cycles for a monotonic pd_dn.
- cal_done rises the cycle after the ADJUST that completes lock.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- AIBND_DCC_TRACK_EN defined:
  - LOCKED keeps looping SETTLE→SAMPLE→ADJUST internally.
  - cal_done stays 1, and cal_busy stays 0 while locked.
  - Code steps ±1 per decision; timeouts are ignored.
- Not defined: LOCKED is terminal until cal_en=0 or rst; pd_dn is ignored.

## Structure
- Package aibnd_dcc_pkg holds:
  - the state enum;
  - the direction encoding (DIR_UP, DIR_DN);
  - the timeout multiplier constant (4).
- Sub-module aibnd_dcc_filt holds the accumulator, sample counter and decision/timeout outputs. It is cleared by the controller on SETTLE entry.

## Test plan
Defaults for all scenarios: CODE_W=5, SETTLE_CYC=8, FILT_TH=4, LOCK_TOGGLES=4.
- Reset: rst=1 for 2 cycles → dcc_code=16, cal_busy=0, cal_done=0, cal_sat=0.
- Monotonic: cal_en=1 with pd_dn=1 → dcc_code=15 at cycle 14, then decrements every 13 cycles to 0. The next 4 blocked steps set cal_sat=1 and cal_done=1.
- Dither:
  - Sequence: pd_dn=1 for 4 samples, then pd_dn=0 for 4 samples, alternating.
  - Expected: code sequence 16→15→16→15…; cal_done=1 after the 4th reversal; cal_sat=0.
- No decision: pd_dn toggles every cycle → a timeout every 16 samples. cal_done=1 after 4 timeouts with dcc_code=16.
- Abort: cal_en=0 during SAMPLE at code 14 → IDLE next cycle, cal_busy=0, dcc_code=14. cal_en=1 again → resumes from 14.
- Tracking:
  - Setup: after lock at 16, hold pd_dn=1.
  - With AIBND_DCC_TRACK_EN: code reaches 15 within 13 cycles and cal_done stays 1.
  - Without it: code stays 16.

Source files
------------

// File: rtl/aibnd_dcc_pkg.sv
// Shared definitions for the DCC calibration controller.
//   - FSM state encodings (plain constants for legacy tools)
//   - trim-step direction encoding
//   - timeout multiplier: a sample window with no decision lasts
//     TMO_MULT*FILT_TH samples
package aibnd_dcc_pkg;

  typedef logic [2:0] dcc_state_t;

  localparam dcc_state_t ST_IDLE   = 3'd0;
  localparam dcc_state_t ST_SETTLE = 3'd1;
  localparam dcc_state_t ST_SAMPLE = 3'd2;
  localparam dcc_state_t ST_ADJUST = 3'd3;
  localparam dcc_state_t ST_LOCKED = 3'd4;

  localparam logic DIR_UP = 1'b0;  // increment trim code
  localparam logic DIR_DN = 1'b1;  // decrement trim code

  localparam int TMO_MULT = 4;

endpackage

// File: rtl/aibnd_dcc_filt.sv
// Phase-detector decision filter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clears accumulator and sample counter (held while not sampling)
//   en        - one phase-detector sample is taken this cycle
//   pd_dn     - sample value, 1 = duty too high
//   dec       - this sample brings the accumulator to +/-FILT_TH
//   dec_dir   - direction of that decision (DIR_DN at +FILT_TH)
//   tmo       - this sample completes the window without a decision
// dec/dec_dir/tmo are combinational from the current sample so the
// controller can leave SAMPLE on the deciding cycle.
module aibnd_dcc_filt import aibnd_dcc_pkg::*; #(
  parameter int FILT_TH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic pd_dn,
  output logic dec,
  output logic dec_dir,
  output logic tmo
);

  localparam int ACC_W = $clog2(FILT_TH) + 2;
  localparam int CNT_W = $clog2(TMO_MULT * FILT_TH) + 1;

  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);
  localparam logic signed [ACC_W-1:0] TH_P    = ACC_W'(FILT_TH);
  localparam logic signed [ACC_W-1:0] TH_N    = -TH_P;
  localparam logic [CNT_W-1:0]        CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_END = CNT_W'(TMO_MULT * FILT_TH);

  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;

  always_comb begin
    acc_nxt = pd_dn ? (acc + ACC_ONE) : (acc - ACC_ONE);
    cnt_nxt = cnt + CNT_ONE;
    dec     = en && ((acc_nxt == TH_P) || (acc_nxt == TH_N));
    dec_dir = (acc_nxt == TH_P) ? DIR_DN : DIR_UP;
    tmo     = en && !dec && (cnt_nxt == CNT_END);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en) begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/aibnd_dcc_cal_ctl.sv
// Duty-cycle-correction calibration controller.
// Settles, filters phase-detector samples, steps the trim code by one
// and declares lock after LOCK_TOGGLES reversal/saturation/timeout events.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   vcc_aibnd, vss_aibnd - supply pins, no logic function
//   cal_en               - level enable; low aborts to IDLE (code held)
//   pd_dn                - phase-detector sample, 1 = decrement code
//   dcc_code             - registered trim code, resets to midscale
//   cal_busy             - calibrating (SETTLE/SAMPLE/ADJUST)
//   cal_done             - locked
//   cal_sat              - sticky: a step was blocked at 0 or max
// Build option AIBND_DCC_TRACK_EN: after lock the loop keeps running
// with cal_done=1/cal_busy=0, stepping on decisions and ignoring
// timeouts. The trk flag marks that locked-tracking mode, so the state
// register cycles SETTLE/SAMPLE/ADJUST instead of sitting in LOCKED.
// Handshake: none; cal_en is a plain level, pd_dn is sampled every
// SAMPLE cycle, all outputs are registered.
module aibnd_dcc_cal_ctl import aibnd_dcc_pkg::*; #(
  parameter int CODE_W       = 5,
  parameter int SETTLE_CYC   = 8,
  parameter int FILT_TH      = 4,
  parameter int LOCK_TOGGLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vcc_aibnd,
  input  logic              vss_aibnd,
  input  logic              cal_en,
  input  logic              pd_dn,
  output logic [CODE_W-1:0] dcc_code,
  output logic              cal_busy,
  output logic              cal_done,
  output logic              cal_sat
);

`ifdef AIBND_DCC_TRACK_EN
  localparam logic TRACK = 1'b1;
`else
  localparam logic TRACK = 1'b0;
`endif

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam int EV_W = $clog2(LOCK_TOGGLES + 1);

  localparam logic [CODE_W-1:0] CODE_MID = {1'b1, {(CODE_W-1){1'b0}}};
  localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};
  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);
  localparam logic [SC_W-1:0]   SC_LAST  = SC_W'(SETTLE_CYC - 1);
  localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);
  localparam logic [EV_W-1:0]   EV_MAX   = EV_W'(LOCK_TOGGLES);
  localparam logic [EV_W-1:0]   EV_ONE   = EV_W'(1);

  logic unused_pwr;
  assign unused_pwr = vcc_aibnd ^ vss_aibnd;

  dcc_state_t        state, state_nxt;
  logic [SC_W-1:0]   scnt;
  logic [EV_W-1:0]   evt, evt_nxt, evt_inc;
  logic [CODE_W-1:0] code_nxt;
  logic              last_vld, last_vld_nxt;
  logic              last_dir, last_dir_nxt;
  logic              adj_dir;
  logic              trk, trk_nxt;
  logic              sat_nxt, busy_nxt, done_nxt;
  logic              blocked, lock_now;
  logic              f_dec, f_dir, f_tmo;

  aibnd_dcc_filt #(.FILT_TH(FILT_TH)) u_filt (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != ST_SAMPLE),
    .en      ((state == ST_SAMPLE) && cal_en),
    .pd_dn   (pd_dn),
    .dec     (f_dec),
    .dec_dir (f_dir),
    .tmo     (f_tmo)
  );

  always_comb begin
    state_nxt    = state;
    code_nxt     = dcc_code;
    evt_nxt      = evt;
    last_vld_nxt = last_vld;
    last_dir_nxt = last_dir;
    trk_nxt      = trk;
    sat_nxt      = cal_sat;
    blocked      = 1'b0;
    lock_now     = 1'b0;
    evt_inc      = (evt == EV_MAX) ? evt : (evt + EV_ONE);

    if (!cal_en) begin
      state_nxt = ST_IDLE;
      trk_nxt   = 1'b0;
      sat_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt    = ST_SETTLE;
          evt_nxt      = '0;
          last_vld_nxt = 1'b0;
          last_dir_nxt = DIR_UP;
        end
        ST_SETTLE: begin
          if (scnt == SC_LAST) state_nxt = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (f_dec) begin
            state_nxt = ST_ADJUST;
          end else if (f_tmo) begin
            state_nxt = ST_SETTLE;
            if (!trk) begin
              evt_nxt  = evt_inc;
              lock_now = (evt_inc == EV_MAX);
            end
          end
        end
        ST_ADJUST: begin
          state_nxt = ST_SETTLE;
          blocked   = (adj_dir == DIR_DN) ? (dcc_code == '0) : (dcc_code == CODE_MAX);
          if (blocked) sat_nxt = 1'b1;
          else if (adj_dir == DIR_DN) code_nxt = dcc_code - CODE_ONE;
          else code_nxt = dcc_code + CODE_ONE;
          if (!trk) begin
            // a blocked step and a reversal in the same step count once
            if (blocked || (last_vld && (adj_dir != last_dir))) begin
              evt_nxt  = evt_inc;
              lock_now = (evt_inc == EV_MAX);
            end
            last_vld_nxt = 1'b1;
            last_dir_nxt = adj_dir;
          end
        end
        ST_LOCKED: ;
        default: state_nxt = ST_IDLE;
      endcase

      if (lock_now) begin
        if (TRACK) begin
          state_nxt = ST_SETTLE;
          trk_nxt   = 1'b1;
        end else begin
          state_nxt = ST_LOCKED;
        end
      end
    end

    busy_nxt = ((state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE) ||
                (state_nxt == ST_ADJUST)) && !trk_nxt;
    done_nxt = (state_nxt == ST_LOCKED) || trk_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      dcc_code <= CODE_MID;
      scnt     <= '0;
      evt      <= '0;
      last_vld <= 1'b0;
      last_dir <= DIR_UP;
      adj_dir  <= DIR_UP;
      trk      <= 1'b0;
      cal_busy <= 1'b0;
      cal_done <= 1'b0;
      cal_sat  <= 1'b0;
    end else begin
      state    <= state_nxt;
      dcc_code <= code_nxt;
      evt      <= evt_nxt;
      last_vld <= last_vld_nxt;
      last_dir <= last_dir_nxt;
      trk      <= trk_nxt;
      cal_busy <= busy_nxt;
      cal_done <= done_nxt;
      cal_sat  <= sat_nxt;
      // counts only while settling; zero on every SETTLE entry
      scnt     <= ((state == ST_SETTLE) && cal_en) ? (scnt + SC_ONE) : '0;
      if ((state == ST_SAMPLE) && f_dec) adj_dir <= f_dir;
    end
  end

endmodule

// File: tb/tb_aibnd_dcc_cal_ctl.sv
// Testbench for aibnd_dcc_cal_ctl (defaults CODE_W=5, SETTLE_CYC=8,
// FILT_TH=4, LOCK_TOGGLES=4). Cycle numbers follow the controller's
// timing: cycle 0 is the cycle cal_en is first sampled high in IDLE.
module tb_aibnd_dcc_cal_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cal_en = 1'b0;
  logic       pd_dn = 1'b0;
  logic [4:0] dcc_code;
  logic       cal_busy, cal_done, cal_sat;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mode   = 0;  // 0: pd_dn=1, 1: dither on code, 2: toggle each cycle

  // clock / reset block
  always #5 clk = ~clk;

  aibnd_dcc_cal_ctl #(
    .CODE_W(5), .SETTLE_CYC(8), .FILT_TH(4), .LOCK_TOGGLES(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vcc_aibnd (1'b1),
    .vss_aibnd (1'b0),
    .cal_en    (cal_en),
    .pd_dn     (pd_dn),
    .dcc_code  (dcc_code),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_sat   (cal_sat)
  );

  typedef struct {
    int         scen;
    int         cyc;
    int         pd_mode;
    logic [4:0] code;
    logic       busy;
    logic       done;
    logic       sat;
  } vec_t;

  vec_t vt[40];
  int   nv = 0;

  task automatic add(input int s, input int c, input int m, input logic [4:0] cd,
                     input logic b, input logic d, input logic st);
    vt[nv].scen = s; vt[nv].cyc = c; vt[nv].pd_mode = m;
    vt[nv].code = cd; vt[nv].busy = b; vt[nv].done = d; vt[nv].sat = st;
    nv++;
  endtask

  // driver tasks
  task automatic drive_pd();
    case (mode)
      1:       pd_dn = (dcc_code == 5'd16);
      2:       pd_dn = (cyc % 2 == 0);
      default: pd_dn = 1'b1;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive_pd();
  endtask

  task automatic check(input string nm, input logic [4:0] ec, input logic eb,
                       input logic ed, input logic es);
    n_chk++;
    if (dcc_code !== ec || cal_busy !== eb || cal_done !== ed || cal_sat !== es) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got code=%0d busy=%b done=%b sat=%b want code=%0d busy=%b done=%b sat=%b",
               nm, cyc, dcc_code, cal_busy, cal_done, cal_sat, ec, eb, ed, es);
    end
  endtask

  // reset with cal_en already high: reset must win, then run from cycle 0
  task automatic start_scen(input int m);
    rst = 1'b1;
    cal_en = 1'b1;
    mode = m;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset", 5'd16, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc = 0;
    drive_pd();
  endtask

  initial begin
    // scenario 0: monotonic pd_dn=1, down to 0, then 4 blocked steps
    add(0,   1, 0, 5'd16, 1, 0, 0);
    add(0,  13, 0, 5'd16, 1, 0, 0);
    add(0,  14, 0, 5'd15, 1, 0, 0);
    add(0,  27, 0, 5'd14, 1, 0, 0);
    add(0, 208, 0, 5'd1,  1, 0, 0);
    add(0, 209, 0, 5'd0,  1, 0, 0);
    add(0, 221, 0, 5'd0,  1, 0, 0);
    add(0, 222, 0, 5'd0,  1, 0, 1);
    add(0, 260, 0, 5'd0,  1, 0, 1);
    add(0, 261, 0, 5'd0,  0, 1, 1);
    add(0, 300, 0, 5'd0,  0, 1, 1);
    // scenario 1: dither around 16/15, lock on the 4th reversal
    add(1,   1, 1, 5'd16, 1, 0, 0);
    add(1,  14, 1, 5'd15, 1, 0, 0);
    add(1,  27, 1, 5'd16, 1, 0, 0);
    add(1,  40, 1, 5'd15, 1, 0, 0);
    add(1,  53, 1, 5'd16, 1, 0, 0);
    add(1,  65, 1, 5'd16, 1, 0, 0);
    add(1,  66, 1, 5'd15, 0, 1, 0);
    add(1, 100, 1, 5'd15, 0, 1, 0);
    // scenario 2: toggling pd_dn, 4 timeouts, then pd_dn held high
    add(2,   1, 2, 5'd16, 1, 0, 0);
    add(2,  24, 2, 5'd16, 1, 0, 0);
    add(2,  96, 2, 5'd16, 1, 0, 0);
    add(2,  97, 2, 5'd16, 0, 1, 0);
`ifdef AIBND_DCC_TRACK_EN
    add(2, 110, 0, 5'd15, 0, 1, 0);
    add(2, 120, 0, 5'd15, 0, 1, 0);
`else
    add(2, 110, 0, 5'd16, 0, 1, 0);
    add(2, 120, 0, 5'd16, 0, 1, 0);
`endif

    for (int i = 0; i < nv; i++) begin
      if (i == 0 || vt[i].scen != vt[i-1].scen) start_scen(vt[i].pd_mode);
      mode = vt[i].pd_mode;
      drive_pd();
      while (cyc < vt[i].cyc) tick();
      check($sformatf("vec%0d_s%0d", i, vt[i].scen), vt[i].code, vt[i].busy,
            vt[i].done, vt[i].sat);
    end

    // abort during SAMPLE at code 14, then resume from 14
    start_scen(0);
    while (cyc < 36) tick();
    check("abort_pre", 5'd14, 1'b1, 1'b0, 1'b0);
    cal_en = 1'b0;
    tick();
    check("abort_idle", 5'd14, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    check("abort_hold", 5'd14, 1'b0, 1'b0, 1'b0);
    cal_en = 1'b1;
    cyc = 0;
    while (cyc < 13) tick();
    check("resume_13", 5'd14, 1'b1, 1'b0, 1'b0);
    tick();
    check("resume_14", 5'd13, 1'b1, 1'b0, 1'b0);

    // dropping cal_en after a saturated lock clears done/sat, holds code
    start_scen(0);
    while (cyc < 261) tick();
    check("sat_lock", 5'd0, 1'b0, 1'b1, 1'b1);
    cal_en = 1'b0;
    tick();
    check("sat_clear", 5'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
